// File: rtl/truth_table_sequencer.sv
// Stimulus sequencer and response collector for 4-input function blocks.
// Sweeps every input vector in ascending order and records the block outputs in a truth table.
module truth_table_sequencer #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 5,
  parameter int HOLD  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      stim,
  input  logic [N_OUT-1:0]     resp,
  output logic                 busy,
  output logic                 done,
  output logic                 sample_valid,
  output logic [N_IN-1:0]      sample_index,
  output logic [N_OUT-1:0]     sample_data,
  input  logic [2:0]           rd_sel,
  output logic [2**N_IN-1:0]   rd_column
);

  localparam int              NVEC      = 2**N_IN;
  localparam logic [7:0]      HOLD_LAST = 8'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

  state_t                       state_q, state_d;
  // The vector counter and the driven stimulus are the same register.
  logic [N_IN-1:0]              stim_q, stim_d;
  logic [7:0]                   hold_q, hold_d;
  logic                         sv_q, sv_d;
  logic [N_IN-1:0]              idx_q, idx_d;
  logic [N_OUT-1:0]             data_q, data_d;
  logic [NVEC-1:0][N_OUT-1:0]   tt_q, tt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      hold_q  <= '0;
      sv_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      hold_q  <= hold_d;
      sv_q    <= sv_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tt_q    <= tt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    hold_d  = hold_q;
    sv_d    = 1'b0;
    idx_d   = idx_q;
    data_d  = data_q;
    tt_d    = tt_q;
    if (abort) begin
      // Partial results stay in the table so they can still be read out.
      state_d = S_IDLE;
      stim_d  = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_APPLY;
            stim_d  = '0;
            hold_d  = '0;
            tt_d    = '0;
          end
        end
        S_APPLY: begin
          if (hold_q == HOLD_LAST) begin
            tt_d[stim_q] = resp;
            idx_d        = stim_q;
            data_d       = resp;
            sv_d         = 1'b1;
            hold_d       = '0;
            if (stim_q != VEC_LAST) stim_d = stim_q + 1'b1;
            else                    state_d = S_DONE;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign stim         = stim_q;
  assign busy         = (state_q == S_APPLY);
  assign done         = (state_q == S_DONE);
  assign sample_valid = sv_q;
  assign sample_index = idx_q;
  assign sample_data  = data_q;

  always_comb begin
    rd_column = '0;
    if (int'(rd_sel) < N_OUT) begin
      for (int i = 0; i < NVEC; i++) rd_column[i] = tt_q[i][rd_sel];
    end
  end

endmodule
